// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Holds the stage FSM encoding and the default data-memory geometry.
package mem_stage_pkg;

  // Default data memory size (8-bit words) and matching address width.
  localparam int DM_DEPTH = 32;
  localparam int DM_AW    = 5;

  // IDLE accepts instructions; LOAD_WAIT covers the registered memory read.
  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem.sv
// Data memory for the memory-access stage: DEPTH x 8 words, synchronous
// write, registered read and a synchronous clear of every word on reset.
// Build option DM_PARITY_EN widens each word with an even-parity bit and
// reports a parity mismatch on the registered read word.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o,
  output logic          perr_o
);

`ifdef DM_PARITY_EN
  localparam int WW = 9;
`else
  localparam int WW = 8;
`endif

  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rword_q;
  logic [WW-1:0] wword;

`ifdef DM_PARITY_EN
  // Bit 8 makes the total number of ones in the stored word even.
  assign wword  = {^wdata_i, wdata_i};
  assign perr_o = ^rword_q;
`else
  assign wword  = wdata_i;
  assign perr_o = 1'b0;
`endif

  assign rdata_o = rword_q[7:0];

  // Clear the whole array on reset, otherwise write and/or read the addressed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rword_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wword;
      end
      if (re_i) begin
        rword_q <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Non-load instructions retire one cycle after
// transfer at full throughput; loads stall one extra cycle while the
// registered memory read completes. Out-of-range accesses and conflicting
// read+write controls are suppressed and raise a sticky err flag.
// Optional build macro: DM_PARITY_EN (per-word parity, mismatch sets err).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] alu_result,
  input  logic [7:0] store_data,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       mem_to_reg,
  input  logic [2:0] rd_in,
  input  logic       reg_write_in,
  output logic [7:0] mux_ans_dm,
  output logic [2:0] rd_out,
  output logic       reg_write_out,
  output logic       out_valid,
  output logic       err
);

  state_t        state_q;
  logic [7:0]    mux_ans_q;
  logic [2:0]    rd_out_q;
  logic          reg_write_out_q;
  logic          out_valid_q;
  logic          err_q;

  // Load context captured on the transfer edge and consumed in LOAD_WAIT.
  logic [7:0]    ld_alu_q;
  logic [2:0]    ld_rd_q;
  logic          ld_reg_write_q;
  logic          ld_mem_to_reg_q;
  logic          ld_oor_q;

  logic          xfer;
  logic          is_load;
  logic          is_store;
  logic          is_both;
  logic          oor;
  logic [AW-1:0] addr;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic          mem_perr;

  assign in_ready = (state_q == IDLE);
  assign xfer     = in_valid & in_ready;
  assign is_load  = mem_read & ~mem_write;
  assign is_store = mem_write & ~mem_read;
  assign is_both  = mem_read & mem_write;
  assign addr     = alu_result[AW-1:0];
  // Any set bit above the address field means the access is out of range.
  assign oor      = (alu_result >> AW) != 8'h00;
  assign mem_we   = xfer & is_store & ~oor;
  assign mem_re   = xfer & is_load & ~oor;

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr),
    .wdata_i (store_data),
    .rdata_o (mem_rdata),
    .perr_o  (mem_perr)
  );

  // Stage FSM with registered outputs; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mux_ans_q       <= 8'h00;
      rd_out_q        <= 3'd0;
      reg_write_out_q <= 1'b0;
      out_valid_q     <= 1'b0;
      err_q           <= 1'b0;
      ld_alu_q        <= 8'h00;
      ld_rd_q         <= 3'd0;
      ld_reg_write_q  <= 1'b0;
      ld_mem_to_reg_q <= 1'b0;
      ld_oor_q        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if ((oor && (is_load || is_store)) || is_both) begin
              err_q <= 1'b1;
            end
            if (is_load) begin
              state_q         <= LOAD_WAIT;
              ld_alu_q        <= alu_result;
              ld_rd_q         <= rd_in;
              ld_reg_write_q  <= reg_write_in;
              ld_mem_to_reg_q <= mem_to_reg;
              ld_oor_q        <= oor;
            end else begin
              out_valid_q     <= 1'b1;
              mux_ans_q       <= alu_result;
              rd_out_q        <= rd_in;
              reg_write_out_q <= reg_write_in;
            end
          end
        end
        LOAD_WAIT: begin
          state_q         <= IDLE;
          out_valid_q     <= 1'b1;
          rd_out_q        <= ld_rd_q;
          reg_write_out_q <= ld_reg_write_q;
          if (ld_oor_q) begin
            mux_ans_q <= 8'h00;
          end else if (ld_mem_to_reg_q) begin
            mux_ans_q <= mem_rdata;
          end else begin
            mux_ans_q <= ld_alu_q;
          end
          // Parity is only meaningful when the read actually happened.
          if (!ld_oor_q && mem_perr) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mux_ans_dm    = mux_ans_q;
  assign rd_out        = rd_out_q;
  assign reg_write_out = reg_write_out_q;
  assign out_valid     = out_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of instruction vectors with
// hand-computed expected results, a scoreboard queue popped on out_valid, and
// hand-written sequences for reset corner cases (and parity when enabled).
module tb_mem_access_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_result;
  logic [7:0] store_data;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic [2:0] rd_in;
  logic       reg_write_in;
  logic [7:0] mux_ans_dm;
  logic [2:0] rd_out;
  logic       reg_write_out;
  logic       out_valid;
  logic       err;

  mem_access_stage #(.DEPTH(32), .AW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .mux_ans_dm    (mux_ans_dm),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .out_valid     (out_valid),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] alu;
    logic [7:0] sd;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic [2:0] rd;
    logic       rw;
    logic [7:0] exp_data;
    logic       exp_err;
    logic       b2b;
  } vec_t;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  rd;
    logic        rw;
    logic        err;
    int unsigned cyc;
  } exp_t;

  vec_t        tbl [18];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every retired instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got 1 want 0");
      end else begin
        mon_e = exp_q.pop_front();
        $display("tx cyc=%0d data=%h rd=%0d rw=%0d err=%0d", cyc, mux_ans_dm, rd_out, reg_write_out, err);
        chk("data", int'(mux_ans_dm), int'(mon_e.data));
        chk("rd_out", int'(rd_out), int'(mon_e.rd));
        chk("reg_write_out", int'(reg_write_out), int'(mon_e.rw));
        chk("err", int'(err), int'(mon_e.err));
        chk("latency_cycle", int'(cyc), int'(mon_e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input vec_t v);
    int waitn;
    int lat;
    waitn = 0;
    while (in_ready !== 1'b1 && waitn < 10) begin
      @(negedge clk);
      waitn++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
      return;
    end
    if (v.b2b) chk("b2b_ready_stall", waitn, 0);
    alu_result   = v.alu;
    store_data   = v.sd;
    mem_read     = v.mr;
    mem_write    = v.mw;
    mem_to_reg   = v.m2r;
    rd_in        = v.rd;
    reg_write_in = v.rw;
    in_valid     = 1'b1;
    lat = (v.mr && !v.mw) ? 2 : 1;
    exp_q.push_back('{v.exp_data, v.rd, v.rw, v.exp_err, cyc + lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send(tbl[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Reset for two edges; optionally offers a store that must be discarded.
  task automatic do_reset(input logic with_store);
    reset = 1'b1;
    exp_q.delete();
    if (with_store) begin
      alu_result = 8'h03; store_data = 8'hFF; mem_read = 1'b0; mem_write = 1'b1;
      mem_to_reg = 1'b0; rd_in = 3'd7; reg_write_in = 1'b1; in_valid = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mux_ans_dm", int'(mux_ans_dm), 0);
    chk("rst_rd_out", int'(rd_out), 0);
    chk("rst_reg_write_out", int'(reg_write_out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    //        alu    sd     mr mw m2r rd rw exp    err b2b
    tbl[0]  = '{8'h03, 8'hA5, 0, 1, 0, 1, 0, 8'h03, 0, 0}; // store A5 -> [3]
    tbl[1]  = '{8'h03, 8'h00, 1, 0, 1, 2, 1, 8'hA5, 0, 0}; // load [3]
    tbl[2]  = '{8'h01, 8'h00, 0, 0, 0, 3, 1, 8'h01, 0, 0}; // ALU ops 1..4
    tbl[3]  = '{8'h02, 8'h00, 0, 0, 0, 4, 1, 8'h02, 0, 1};
    tbl[4]  = '{8'h03, 8'h00, 0, 0, 0, 5, 1, 8'h03, 0, 1};
    tbl[5]  = '{8'h04, 8'h00, 0, 0, 0, 6, 1, 8'h04, 0, 1};
    tbl[6]  = '{8'h03, 8'h00, 1, 0, 0, 7, 1, 8'h03, 0, 0}; // load, mem_to_reg=0
    tbl[7]  = '{8'h03, 8'h5A, 0, 1, 0, 0, 0, 8'h03, 0, 0}; // store 5A -> [3]
    tbl[8]  = '{8'h03, 8'h00, 1, 0, 1, 1, 1, 8'h5A, 0, 0}; // load right after store
    tbl[9]  = '{8'h40, 8'h00, 1, 0, 1, 2, 1, 8'h00, 1, 0}; // out-of-range load
    tbl[10] = '{8'h11, 8'h00, 0, 0, 0, 3, 1, 8'h11, 1, 0}; // err sticky
    tbl[11] = '{8'h80, 8'h77, 0, 1, 0, 4, 0, 8'h80, 1, 0}; // out-of-range store
    tbl[12] = '{8'h07, 8'h31, 0, 1, 0, 4, 0, 8'h07, 0, 0}; // store 31 -> [7]
    tbl[13] = '{8'h07, 8'hEE, 1, 1, 1, 5, 1, 8'h07, 1, 0}; // read+write conflict
    tbl[14] = '{8'h07, 8'h00, 1, 0, 1, 6, 1, 8'h31, 1, 0}; // [7] unchanged
    tbl[15] = '{8'h03, 8'h00, 1, 0, 1, 1, 1, 8'h00, 0, 0}; // cleared by reset
    tbl[16] = '{8'h83, 8'h99, 0, 1, 0, 2, 0, 8'h83, 1, 0}; // oor store aliasing [3]
    tbl[17] = '{8'h03, 8'h00, 1, 0, 1, 3, 1, 8'h00, 1, 0}; // [3] not written

    in_valid = 1'b0; alu_result = 8'h00; store_data = 8'h00; mem_read = 1'b0;
    mem_write = 1'b0; mem_to_reg = 1'b0; rd_in = 3'd0; reg_write_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    do_reset(1'b0);

    run_range(0, 12);
    drain();
    chk("err_sticky_idle", int'(err), 1);

    do_reset(1'b1);
    run_range(12, 15);
    drain();

    do_reset(1'b0);
    // Abort a load with reset while in LOAD_WAIT.
    send('{8'h03, 8'h00, 1, 0, 1, 2, 1, 8'h00, 0, 0});
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", int'(out_valid), 0);
    reset = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    chk("abort_no_pulse", int'(out_valid), 0);
    run_range(15, 18);
    drain();

`ifdef DM_PARITY_EN
    do_reset(1'b0);
    send('{8'h05, 8'h3C, 0, 1, 0, 1, 0, 8'h05, 0, 0});
    drain();
    dut.u_mem.mem_q[5][8] = ~dut.u_mem.mem_q[5][8];
    send('{8'h05, 8'h00, 1, 0, 1, 2, 1, 8'h3C, 1, 0});
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
